// File: rtl/dec_disp_pkg.sv
// rtl/dec_disp_pkg.sv - shared constants and FSM encoding for the sequential decimal display
package dec_disp_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    typedef logic [1:0] dec_state_t;

    localparam dec_state_t ST_IDLE  = 2'd0;
    localparam dec_state_t ST_SHIFT = 2'd1;
    localparam dec_state_t ST_DONE  = 2'd2;

    // Double-dabble correction applied to each digit before the next shift.
    function automatic logic [BCD_W-1:0] add3_digit(input logic [BCD_W-1:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/seven_segment.sv
// rtl/seven_segment.sv - BCD digit to active-high seven-segment code (bit0 = a .. bit6 = g)
module seven_segment (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seven_segment_negative.sv
// rtl/seven_segment_negative.sv - sign digit: segment g only when negative, blank otherwise
module seven_segment_negative (
    input  logic       neg,
    output logic [6:0] seg
);

    assign seg = neg ? 7'h40 : 7'h00;

endmodule

// File: rtl/seq_decimal_display.sv
// rtl/seq_decimal_display.sv - sequential double-dabble converter with seven-segment outputs; DEC_DISP_SIGNED_EN selects two's complement input
module seq_decimal_display
    import dec_disp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          val,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      overflow,
    output logic                      is_negative,
    output logic [SEG_W*DIGITS-1:0]   seg7_digits,
    output logic [SEG_W-1:0]          seg7_neg_sign
);

    localparam int BCD_BITS = BCD_W * DIGITS;
    localparam int CNT_W    = $clog2(WIDTH + 1);

    dec_state_t           state;
    logic [WIDTH-1:0]     mag_r;
    logic [BCD_BITS-1:0]  shreg;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf_acc;
    logic                 neg_acc;
    logic [BCD_BITS-1:0]  bcd_r;
    logic                 ovf_r;
    logic                 neg_r;
    logic                 done_r;

    logic [WIDTH-1:0]     mag_in;
    logic                 neg_in;
    logic [BCD_BITS-1:0]  adj;
    logic [BCD_BITS-1:0]  shifted;
    logic                 carry_out;

`ifdef DEC_DISP_SIGNED_EN
    // Negating the most negative value wraps to itself, which is exactly its magnitude when read unsigned.
    assign neg_in = val[WIDTH-1];
    assign mag_in = neg_in ? -val : val;
`else
    assign neg_in = 1'b0;
    assign mag_in = val;
`endif

    always_comb begin
        adj = shreg;
        for (int i = 0; i < DIGITS; i++) begin
            adj[i*BCD_W +: BCD_W] = add3_digit(shreg[i*BCD_W +: BCD_W]);
        end
    end

    assign shifted   = {adj[BCD_BITS-2:0], mag_r[WIDTH-1]};
    assign carry_out = adj[BCD_BITS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mag_r   <= '0;
            shreg   <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            neg_acc <= 1'b0;
            bcd_r   <= '0;
            ovf_r   <= 1'b0;
            neg_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mag_r   <= mag_in;
                        neg_acc <= neg_in;
                        shreg   <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CNT_W'(WIDTH);
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg   <= shifted;
                    mag_r   <= mag_r << 1;
                    ovf_acc <= ovf_acc | carry_out;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_r  <= shreg;
                    ovf_r  <= ovf_acc;
                    neg_r  <= neg_acc;
                    done_r <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign done        = done_r;
    assign bcd         = bcd_r;
    assign overflow    = ovf_r;
    assign is_negative = neg_r;

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seven_segment u_seg (
            .digit (bcd_r[g*BCD_W +: BCD_W]),
            .seg   (seg7_digits[g*SEG_W +: SEG_W])
        );
    end

    seven_segment_negative u_neg (
        .neg (is_negative),
        .seg (seg7_neg_sign)
    );

endmodule

// File: doc/seq_decimal_display.md
SEQ_DECIMAL_DISPLAY -- requirements
Module: seq_decimal_display

Interface
REQ-001 SHALL have parameter WIDTH, default 8, input word width in bits (>=2).
REQ-002 SHALL have parameter DIGITS, default 3, decimal digit count (>=1).
REQ-003 SHALL use one clock, with synchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-007 SHALL have port val  input  WIDTH  value to convert, sampled with start.
REQ-008 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result registers update.
REQ-010 SHALL have port bcd  output  4*DIGITS  registered BCD result, digit 0 in bits [3:0].
REQ-011 SHALL have port overflow  output  1  registered; magnitude >= 10^DIGITS.
REQ-012 SHALL have port is_negative  output  1  registered sign of the last result.
REQ-013 SHALL have port seg7_digits  output  7*DIGITS  seven-segment codes, digit 0 in bits [6:0].
REQ-014 SHALL have port seg7_neg_sign  output  7  minus pattern if is_negative, else blank.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 SHALL, in IDLE with start=1, capture the magnitude of val, clear the BCD shift register, load bit counter=WIDTH and go to SHIFT.
REQ-017 SHALL, in each SHIFT cycle, add 3 to every BCD digit >=5, then shift one magnitude bit (MSB first) into the BCD LSB.
REQ-018 SHALL set an internal overflow flag if any 1 is shifted out of the top BCD digit.
REQ-019 SHALL go from SHIFT to DONE after exactly WIDTH shift cycles.
REQ-020 SHALL, in DONE, update bcd, overflow and is_negative, assert done for one cycle and return to IDLE.
REQ-021 SHALL assert done WIDTH+1 rising edges after the edge that sampled start.
REQ-022 SHALL hold busy high from the edge after start is sampled until done is asserted; busy=0 in the done cycle.
REQ-023 SHALL ignore start while in SHIFT or DONE; back-to-back start is accepted in the first IDLE cycle.
REQ-024 SHALL, on overflow, output bcd = magnitude mod 10^DIGITS with overflow=1.
REQ-025 SHALL hold bcd, overflow and is_negative stable between done pulses.
REQ-026 SHALL drive seg7 outputs combinationally from the registered bcd and is_negative only.

Reset
REQ-027 SHALL, with rst=1 at a clock edge (including mid-conversion), enter IDLE and clear busy, done, bcd, overflow, is_negative and the counter.
REQ-028 SHALL abandon an interrupted conversion with no done pulse; after reset, seg7_digits shows all '0' and seg7_neg_sign is blank.

Configuration
REQ-029 SHALL, with DEC_DISP_SIGNED_EN defined, treat val as two's complement: magnitude = -val when val[WIDTH-1]=1, with is_negative set accordingly.
REQ-030 SHALL treat val as signed -2^(WIDTH-1) as magnitude 2^(WIDTH-1), using the full WIDTH bits with no loss.
REQ-031 SHALL, without DEC_DISP_SIGNED_EN, treat val as unsigned, tie is_negative to 0 and keep seg7_neg_sign blank.

Structure
REQ-032 SHALL place the FSM state enum and BCD digit width (4) and seven-segment width (7) constants in shared package dec_disp_pkg.
REQ-033 SHALL instantiate the existing seven_segment decoder once per digit via a generate loop.
REQ-034 SHALL instantiate the existing seven_segment_negative decoder for the sign.
REQ-035 SHALL keep the conversion datapath inline, with no further sub-modules.

Verification (WIDTH=8, DIGITS=3 unless stated)
REQ-036 SHALL cover: val=8'h7B, start pulse -> done exactly 9 edges later, bcd=12'h123, overflow=0, is_negative=0.
REQ-037 SHALL cover: signed build, val=8'hF6 -> bcd=12'h010, is_negative=1, seg7_neg_sign=minus; val=8'h80 -> bcd=12'h128, is_negative=1.
REQ-038 SHALL cover: unsigned build, val=8'h80 -> bcd=12'h128, is_negative=0; val=8'hFF -> bcd=12'h255.
REQ-039 SHALL cover: DIGITS=2, unsigned, val=8'h7F -> bcd=8'h27, overflow=1; then val=8'h63 -> bcd=8'h99, overflow=0.
REQ-040 SHALL cover: start re-pulsed with a different val at cycles 2 and 5 of a conversion -> ignored, single done, result of the first val.
REQ-041 SHALL cover: rst at the 4th SHIFT cycle -> no done, busy=0 next cycle, bcd=0; the next start converts normally.
